// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter slice: memory geometry, the
// memory-map base addresses of the shared byte memory, the arbiter FSM state
// type and the address range check used on every access.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Memory geometry: byte-addressed memory, accessed as 16-bit words made of
    // the bytes at {addr, addr+1}.
    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    // Memory-map base addresses of the shared data structures.
    localparam logic [ADDR_WIDTH-1:0] KNOWN_SINK_COUNT_BASE = 16'h0688;
    localparam logic [ADDR_WIDTH-1:0] Q_VALUE_BASE          = 16'h01C8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

    // A word access touches addr and addr+1, so the last legal word address
    // is depth-2.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a,
                                           input int depth);
        return (int'({16'd0, a}) <= (depth - 2));
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Round-robin winner selection. Candidates are searched starting at
// last_owner+1 (mod N_REQ) and wrapping; the first requester found wins.
// Ports:
//   req        in  N_REQ  requests eligible for this arbitration
//   last_owner in  IDX_W  requester that was served most recently
//   grant      out N_REQ  one-hot winner (all zero when no request)
//   valid      out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_owner,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    localparam int SW = IDX_W + 1;

    // rot_idx[k] is the requester visited k-th in the search order, so
    // rot_req is the request vector rotated to put last_owner+1 at bit 0.
    logic [IDX_W-1:0] rot_idx [N_REQ];
    logic [N_REQ-1:0] rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SW-1:0] sum;
            assign sum          = {1'b0, last_owner} + SW'(gi + 1);
            assign rot_idx[gi]  = (sum >= SW'(N_REQ)) ? IDX_W'(sum - SW'(N_REQ))
                                                      : IDX_W'(sum);
            assign rot_req[gi]  = req[rot_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the lowest search position wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                grant             = '0;
                grant[rot_idx[k]] = 1'b1;
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one word-wide memory port between N_REQ requesters. Arbitration is
// round-robin; an owner may hold the port with lock for read-modify-write
// sequences, and a lock left idle for LOCK_MAX cycles is force-released.
// Each access takes one ACCESS cycle, during which ack[owner] is strobed and
// the memory is driven from latched command registers.
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   req/lock/wr_en       per-requester request, lock and write select
//   addr/wdata           per-requester byte address and write word (slice i)
//   ack/err/rdata        one-hot completion, out-of-range flag, read word
//   lock_timeout         one-cycle pulse when a lock is force-released
//   mem_address/mem_wr_en/mem_data_in/mem_data_out   memory port
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_REQ      = 3,
    parameter int LOCK_MAX   = 15,
    parameter int MEM_DEPTH  = mem_arbiter_pkg::MEM_DEPTH,
    parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [N_REQ-1:0]                        req,
    input  logic [N_REQ-1:0]                        lock,
    input  logic [N_REQ-1:0]                        wr_en,
    input  logic [N_REQ*mem_arbiter_pkg::ADDR_WIDTH-1:0] addr,
    input  logic [N_REQ*WORD_WIDTH-1:0]             wdata,
    output logic [N_REQ-1:0]                        ack,
    output logic                                    err,
    output logic [WORD_WIDTH-1:0]                   rdata,
    output logic                                    lock_timeout,
    output logic [mem_arbiter_pkg::ADDR_WIDTH-1:0]  mem_address,
    output logic                                    mem_wr_en,
    output logic [WORD_WIDTH-1:0]                   mem_data_in,
    input  logic [WORD_WIDTH-1:0]                   mem_data_out
);

    import mem_arbiter_pkg::*;

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W  = $clog2(LOCK_MAX + 1);
    localparam int ADDR_W = ADDR_WIDTH;

    // FSM and command state
    arb_state_t        state_reg;
    logic [IDX_W-1:0]  owner_reg;
    logic [IDX_W-1:0]  last_owner_reg;
    logic [ADDR_W-1:0] cmd_addr_reg;
    logic              cmd_wr_reg;
    logic [WORD_WIDTH-1:0] cmd_wdata_reg;
    logic [CNT_W-1:0]  idle_cnt_reg;
    logic              excl_valid_reg;
    logic [IDX_W-1:0]  excl_idx_reg;
    logic              lock_timeout_reg;

    // Per-requester views of the flattened buses
    logic [ADDR_W-1:0]     addr_arr  [N_REQ];
    logic [WORD_WIDTH-1:0] wdata_arr [N_REQ];
    logic [N_REQ-1:0]      owner_onehot;
    logic [N_REQ-1:0]      excl_mask;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign addr_arr[gi]     = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]    = wdata[gi*WORD_WIDTH +: WORD_WIDTH];
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
            assign excl_mask[gi]    = excl_valid_reg && (excl_idx_reg == IDX_W'(gi));
        end
    endgenerate

    // A force-released owner sits out the next arbitration, but only when
    // somebody else is actually asking; otherwise it may win again.
    logic [N_REQ-1:0] others_req;
    logic [N_REQ-1:0] arb_req;
    assign others_req = req & ~excl_mask;
    assign arb_req    = (others_req != '0) ? others_req : req;

    logic [N_REQ-1:0] pick_grant;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req        (arb_req),
        .last_owner (last_owner_reg),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Command source: the round-robin winner from IDLE, the owner from LOCKED.
    logic [IDX_W-1:0] sel_idx;
    assign sel_idx = (state_reg == ST_LOCKED) ? owner_reg : pick_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            owner_reg        <= '0;
            last_owner_reg   <= IDX_W'(N_REQ - 1);
            cmd_addr_reg     <= '0;
            cmd_wr_reg       <= 1'b0;
            cmd_wdata_reg    <= '0;
            idle_cnt_reg     <= '0;
            excl_valid_reg   <= 1'b0;
            excl_idx_reg     <= '0;
            lock_timeout_reg <= 1'b0;
        end else begin
            lock_timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner_reg      <= pick_idx;
                        cmd_addr_reg   <= addr_arr[sel_idx];
                        cmd_wr_reg     <= wr_en[sel_idx];
                        cmd_wdata_reg  <= wdata_arr[sel_idx];
                        excl_valid_reg <= 1'b0;
                        state_reg      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    last_owner_reg <= owner_reg;
                    idle_cnt_reg   <= '0;
                    state_reg      <= lock[owner_reg] ? ST_LOCKED : ST_IDLE;
                end
                ST_LOCKED: begin
                    if (req[owner_reg]) begin
                        cmd_addr_reg  <= addr_arr[sel_idx];
                        cmd_wr_reg    <= wr_en[sel_idx];
                        cmd_wdata_reg <= wdata_arr[sel_idx];
                        idle_cnt_reg  <= '0;
                        state_reg     <= ST_ACCESS;
                    end else if (!lock[owner_reg]) begin
                        idle_cnt_reg <= '0;
                        state_reg    <= ST_IDLE;
                    end else if (idle_cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
                        // This idle cycle is the LOCK_MAX-th: release the lock.
                        idle_cnt_reg     <= '0;
                        lock_timeout_reg <= 1'b1;
                        excl_valid_reg   <= 1'b1;
                        excl_idx_reg     <= owner_reg;
                        state_reg        <= ST_IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Access-cycle outputs are qualified by reset so that a reset arriving in
    // the ACCESS cycle kills both the ack and the write before the edge.
    logic in_access;
    logic cmd_in_range;
    assign in_access    = (state_reg == ST_ACCESS) && !reset;
    assign cmd_in_range = addr_in_range(cmd_addr_reg, MEM_DEPTH);

    assign ack          = in_access ? owner_onehot : '0;
    assign err          = in_access && !cmd_in_range;
    assign mem_wr_en    = in_access && cmd_wr_reg && cmd_in_range;
    assign rdata        = (in_access && cmd_in_range) ? mem_data_out : '0;
    assign lock_timeout = lock_timeout_reg && !reset;

    // Command registers only load on entry to ACCESS, so the memory address
    // and write data naturally hold their last value in the other states.
    assign mem_address  = reset ? '0 : cmd_addr_reg;
    assign mem_data_in  = reset ? '0 : cmd_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios followed by a randomized phase. A transaction-level
// reference (who is being served, who holds a lock, a shadow copy of memory)
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N     = 3;
    localparam int LMAX  = 15;
    localparam int DEPTH = MEM_DEPTH;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [N-1:0]    req, lock, wr_en;
    logic [N*16-1:0] addr, wdata;
    logic [N-1:0]    ack;
    logic            err;
    logic [15:0]     rdata;
    logic            lock_timeout;
    logic [15:0]     mem_address;
    logic            mem_wr_en;
    logic [15:0]     mem_data_in;
    logic [15:0]     mem_data_out;

    mem_arbiter #(
        .N_REQ      (N),
        .LOCK_MAX   (LMAX),
        .MEM_DEPTH  (DEPTH),
        .WORD_WIDTH (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .lock         (lock),
        .wr_en        (wr_en),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .lock_timeout (lock_timeout),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Attached memory, written by the stimulus process from captured port values
    logic [7:0]  tb_mem [0:DEPTH-1];
    logic [7:0]  shadow [0:DEPTH-1];
    logic [15:0] addr_p1;
    assign addr_p1 = mem_address + 16'd1;

    always_comb begin
        mem_data_out = '0;
        if (int'(mem_address) < DEPTH) mem_data_out[15:8] = tb_mem[mem_address[10:0]];
        if (int'(addr_p1) < DEPTH)     mem_data_out[7:0]  = tb_mem[addr_p1[10:0]];
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic        pend_we;
    logic [15:0] pend_a, pend_d;

    // Reference state
    int          m_serving, m_holder, m_last, m_idle, m_barred;
    bit          m_to, m_wr;
    logic [15:0] m_addr, m_data;

    function automatic bit in_rng(input logic [15:0] a);
        return int'(a) <= DEPTH - 2;
    endfunction

    function automatic int rr_winner(input logic [N-1:0] r, input int last, input int barred);
        logic [N-1:0] elig;
        elig = r;
        if (barred >= 0 && (r & ~(N'(1) << barred)) != '0) elig = r & ~(N'(1) << barred);
        for (int k = 1; k <= N; k++) begin
            if (elig[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic take(input int i);
        m_serving = i;
        m_wr      = wr_en[i];
        m_addr    = addr[i*16 +: 16];
        m_data    = wdata[i*16 +: 16];
    endtask

    task automatic model_step();
        logic [15:0] a1;
        int w;
        if (reset) begin
            m_serving = -1; m_holder = -1; m_last = N - 1; m_idle = 0;
            m_barred = -1; m_to = 0; m_wr = 0; m_addr = '0; m_data = '0;
            return;
        end
        m_to = 0;
        if (m_serving >= 0) begin
            if (m_wr && in_rng(m_addr)) begin
                a1 = m_addr + 16'd1;
                shadow[m_addr[10:0]] = m_data[15:8];
                shadow[a1[10:0]]     = m_data[7:0];
            end
            m_last    = m_serving;
            m_idle    = 0;
            m_holder  = lock[m_serving] ? m_serving : -1;
            m_serving = -1;
        end else if (m_holder >= 0) begin
            if (req[m_holder]) begin
                take(m_holder);
                m_holder = -1;
            end else if (!lock[m_holder]) begin
                m_holder = -1;
            end else begin
                m_idle++;
                if (m_idle == LMAX) begin
                    m_barred = m_holder; m_holder = -1; m_to = 1; m_idle = 0;
                end
            end
        end else begin
            w = rr_winner(req, m_last, m_barred);
            if (w >= 0) begin
                m_barred = -1;
                take(w);
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_ack;
        logic [15:0]  e_rd, a1;
        bit e_err, e_we, e_to;
        logic [15:0] e_ma, e_md;
        e_ack = '0; e_rd = '0; e_err = 0; e_we = 0; e_to = 0; e_ma = '0; e_md = '0;
        if (!reset) begin
            e_ma = m_addr;
            e_md = m_data;
            e_to = m_to;
            if (m_serving >= 0) begin
                e_ack[m_serving] = 1'b1;
                e_err = !in_rng(m_addr);
                e_we  = m_wr && in_rng(m_addr);
                if (in_rng(m_addr)) begin
                    a1   = m_addr + 16'd1;
                    e_rd = {shadow[m_addr[10:0]], shadow[a1[10:0]]};
                end
            end
        end
        chk("ack", ack, e_ack);
        chk("err", err, e_err);
        chk("rdata", rdata, e_rd);
        chk("mem_wr_en", mem_wr_en, e_we);
        chk("lock_timeout", lock_timeout, e_to);
        chk("mem_address", mem_address, e_ma);
        chk("mem_data_in", mem_data_in, e_md);
    endtask

    task automatic tick(input bit rst_mid = 1'b0);
        logic [15:0] p1;
        @(posedge clock);
        if (pend_we && !reset) begin
            p1 = pend_a + 16'd1;
            if (int'(pend_a) < DEPTH) tb_mem[pend_a[10:0]] = pend_d[15:8];
            if (int'(p1) < DEPTH)     tb_mem[p1[10:0]]     = pend_d[7:0];
        end
        model_step();
        if (rst_mid) reset = 1'b1;
        cyc++;
        #1;
        check_outputs();
        pend_we = mem_wr_en;
        pend_a  = mem_address;
        pend_d  = mem_data_in;
        req     = req & ~ack;
    endtask

    task automatic set_cmd(input int i, input bit w, input logic [15:0] a, input logic [15:0] d);
        wr_en[i]          = w;
        addr[i*16 +: 16]  = a;
        wdata[i*16 +: 16] = d;
    endtask

    task automatic reset_pulse();
        req = '0; lock = '0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int order_q[$];
        int when_q[$];
        logic [15:0] wd [N];
        logic [7:0]  save_7ff;
        logic [15:0] save_w8;
        int pulses, pulse_cyc, ack1_cyc, wr_ack_cyc, ack2_cyc, rate;

        reset = 1'b1; req = '0; lock = '0; wr_en = '0; addr = '0; wdata = '0;
        pend_we = 1'b0; pend_a = '0; pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i] = 8'($urandom);
            shadow[i] = tb_mem[i];
        end
        tb_mem[12'h688] = 8'h00; tb_mem[12'h689] = 8'h05;
        tb_mem[12'h68A] = 8'h00; tb_mem[12'h68B] = 8'h04;
        for (int i = 12'h688; i <= 12'h68B; i++) shadow[i] = tb_mem[i];

        // Reset state: all outputs zero while reset is high
        tick(); tick(); tick();
        chk("reset_ack", ack, 3'b000);
        reset = 1'b0;
        tick();

        // Single read of the known-sink-count word
        set_cmd(0, 1'b0, KNOWN_SINK_COUNT_BASE, 16'h0);
        req[0] = 1'b1;
        tick();
        chk("single_ack", ack, 3'b001);
        chk("single_rdata", rdata, 16'h0005);
        chk("single_err", err, 1'b0);
        tick();

        // Contention: three writes arriving together, served 0,1,2
        reset_pulse();
        for (int i = 0; i < N; i++) begin
            wd[i] = 16'($urandom_range(1, 16'hFFFF));
            set_cmd(i, 1'b1, 16'(16'h100 * (i + 1)), wd[i]);
        end
        req = 3'b111;
        for (int k = 0; k < 8; k++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    order_q.push_back(i);
                    when_q.push_back(cyc);
                end
            end
        end
        chk("rr_count", order_q.size(), 3);
        for (int j = 0; j < order_q.size() && j < 3; j++) begin
            chk("rr_order", order_q[j], j);
            if (j > 0) chk("rr_spacing", when_q[j] - when_q[j-1], 2);
        end
        for (int i = 0; i < N; i++) begin
            set_cmd(i, 1'b0, 16'(16'h100 * (i + 1)), 16'h0);
            req[i] = 1'b1;
            tick();
            chk("rr_readback", rdata, wd[i]);
            tick();
        end

        // Locked read-modify-write with requester 2 waiting throughout
        reset_pulse();
        set_cmd(1, 1'b0, 16'h068A, 16'h0);
        lock[1] = 1'b1;
        set_cmd(2, 1'b0, 16'h0100, 16'h0);
        req[1] = 1'b1; req[2] = 1'b1;
        tick();
        chk("rmw_read_ack", ack, 3'b010);
        chk("rmw_read_rdata", rdata, 16'h0004);
        set_cmd(1, 1'b1, 16'h068A, 16'h0005);
        req[1] = 1'b1;
        wr_ack_cyc = -1; ack2_cyc = -1;
        for (int k = 0; k < 12 && ack2_cyc < 0; k++) begin
            tick();
            if (ack[1] && wr_ack_cyc < 0) begin
                wr_ack_cyc = cyc;
                lock[1] = 1'b0;
            end
            if (ack[2]) ack2_cyc = cyc;
        end
        chk("rmw_ack2_seen", ack2_cyc >= 0, 1'b1);
        chk("rmw_ack2_after_release", ack2_cyc > wr_ack_cyc && wr_ack_cyc > 0, 1'b1);
        tick();
        set_cmd(0, 1'b0, 16'h068A, 16'h0);
        req[0] = 1'b1;
        tick();
        chk("rmw_readback", rdata, 16'h0005);
        tick();

        // Lock timeout: owner 0 holds the lock idle while requester 1 waits
        reset_pulse();
        set_cmd(0, 1'b0, Q_VALUE_BASE, 16'h0);
        set_cmd(1, 1'b0, 16'h0010, 16'h0);
        lock[0] = 1'b1;
        req[0] = 1'b1; req[1] = 1'b1;
        pulses = 0; pulse_cyc = -1; ack1_cyc = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (lock_timeout) begin
                pulses++;
                pulse_cyc = k;
            end
            if (ack[1] && ack1_cyc < 0) ack1_cyc = k;
        end
        chk("lk_pulses", pulses, 1);
        chk("lk_pulse_cycle", pulse_cyc, 17);
        chk("lk_ack1_cycle", ack1_cyc, 18);
        lock[0] = 1'b0;
        tick();

        // Range boundary: 0x7FF is out of range, 0x7FE is the last legal word
        save_7ff = tb_mem[11'h7FF];
        set_cmd(0, 1'b1, 16'h07FF, 16'h1234);
        req[0] = 1'b1;
        tick();
        chk("oor_ack", ack, 3'b001);
        chk("oor_err", err, 1'b1);
        chk("oor_wr_en", mem_wr_en, 1'b0);
        tick();
        chk("oor_byte_kept", tb_mem[11'h7FF], save_7ff);
        set_cmd(0, 1'b1, 16'h07FE, 16'hBEEF);
        req[0] = 1'b1;
        tick();
        chk("edge_err", err, 1'b0);
        chk("edge_wr_en", mem_wr_en, 1'b1);
        tick();
        set_cmd(0, 1'b0, 16'h07FE, 16'h0);
        req[0] = 1'b1;
        tick();
        chk("edge_readback", rdata, 16'hBEEF);
        tick();

        // Reset arriving in the ACCESS cycle of a write
        save_w8 = {tb_mem[8], tb_mem[9]};
        set_cmd(0, 1'b1, 16'h0008, 16'hABCD);
        req[0] = 1'b1;
        tick(1'b1);
        chk("rst_mid_ack", ack, 3'b000);
        chk("rst_mid_wr_en", mem_wr_en, 1'b0);
        req = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_mid_mem", {tb_mem[8], tb_mem[9]}, save_w8);
        set_cmd(0, 1'b0, 16'h0008, 16'h0);
        req[0] = 1'b1;
        tick();
        chk("rst_mid_idle_ack", ack, 3'b001);
        chk("rst_mid_readback", rdata, save_w8);
        tick();

        // Randomized traffic; the second half requests sparsely so that
        // locks are more likely to run into the timeout.
        for (int c = 0; c < 1500; c++) begin
            rate = (c < 750) ? 2 : 24;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, rate) == 0) begin
                    if ($urandom_range(0, 9) == 0)
                        set_cmd(i, 1'($urandom_range(0, 1)), 16'(DEPTH - 3 + $urandom_range(0, 4)), 16'($urandom));
                    else
                        set_cmd(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
                    req[i] = 1'b1;
                end
                if ($urandom_range(0, 19) == 0) lock[i] = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N_REQ, default 3, number of requesters sharing the memory port.
REQ-002 Parameter: LOCK_MAX, default 15, maximum idle cycles a lock may be held with no request.
REQ-003 Parameter: MEM_DEPTH, default 2048, byte depth of the attached memory; WORD_WIDTH, default 16.
REQ-004 Ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester access request, held until ack.
- lock  in  N_REQ  owner keeps the grant after its access (read-modify-write).
- wr_en  in  N_REQ  per-requester write (1) / read (0).
- addr  in  N_REQ*16  per-requester byte address; slice i = requester i.
- wdata  in  N_REQ*16  per-requester write word.
- ack  out  N_REQ  one-hot access-complete strobe.
- err  out  1  qualifies ack: address out of range, access suppressed.
- rdata  out  16  read word, valid while ack is high.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.
- mem_address  out  16  to memory address.
- mem_wr_en  out  1  to memory write enable.
- mem_data_in  out  16  to memory write data.
- mem_data_out  in  16  from memory, combinational read of {addr, addr+1}.

Function
REQ-005 FSM states: IDLE, ACCESS, LOCKED.
REQ-006 IDLE: if any req is high at a clock edge, select a winner by round-robin starting at last_owner+1 (mod N_REQ); latch its addr, wr_en and wdata into command registers; record owner; go to ACCESS.
REQ-007 ACCESS lasts exactly one cycle:
- mem_address and mem_data_in are driven from the command registers.
- mem_wr_en = latched wr_en AND address in range.
- ack[owner] = 1; rdata = mem_data_out.
REQ-008 An address is in range iff addr <= MEM_DEPTH-2. Out of range: err = 1 with ack, mem_wr_en = 0, rdata = 0.
REQ-009 Exit from ACCESS: to LOCKED if lock[owner] = 1 at that edge, else to IDLE. last_owner is updated to owner on exit.
REQ-010 A requester drops req at the edge where it observes ack. If req is still high in IDLE or LOCKED, that is a new access.
REQ-011 LOCKED:
- Only the owner's req is considered; other requesters wait.
- Owner req = 1: latch its command, go to ACCESS, clear the idle counter.
- Owner lock = 0 and req = 0: go to IDLE.
- Otherwise the idle counter increments.
REQ-012 Lock timeout: when the idle counter reaches LOCK_MAX in LOCKED, go to IDLE and pulse lock_timeout for one cycle. The next arbitration excludes that owner if any other requester has req high.
REQ-013 Latency: a request sampled at edge E0 gets ack in the cycle after E0, and a write commits at E1. Peak throughput is one access per two cycles.
REQ-014 Simultaneous requests: exactly one winner; ack is never multi-hot. No request is starved longer than N_REQ-1 intervening accesses when no locks are held.
REQ-015 Outside ACCESS:
- ack = 0, err = 0, mem_wr_en = 0, rdata = 0.
- mem_address and mem_data_in hold their last value.

Reset
REQ-016 On reset: state = IDLE, last_owner = N_REQ-1 (requester 0 wins first), idle counter = 0, command registers = 0.
REQ-017 All outputs are 0 while reset is high.
REQ-018 Reset during ACCESS suppresses the write (mem_wr_en = 0 that cycle) and produces no ack.
REQ-019 Reset during LOCKED releases the lock with no lock_timeout pulse.

Structure
REQ-020 MEM_DEPTH, MEM_WIDTH, WORD_WIDTH and the memory-map base addresses (e.g. knownSinkCount 0x688, qValue 0x1C8) live in the shared defines include. They are not duplicated locally.
REQ-021 Round-robin selection is one sub-module, rr_pick (inputs req and last_owner; outputs one-hot grant and valid), instantiated once.

Verification
REQ-022 Single read: req[0], addr 0x688 with memory preloaded to 5 -> ack[0] one cycle later, rdata = 0x0005, err = 0.
REQ-023 Contention: req = 3'b111, all writes to distinct addresses -> acks in order 0, 1, 2, two cycles apart; each value reads back correctly.
REQ-024 Lock RMW: requester 1 with lock = 1 reads 0x68A (value 4) and writes 5, while req[2] is held high throughout -> requester 2 is acked only after the lock is released; 0x68A reads 0x0005.
REQ-025 Lock timeout: requester 0 locks, then idles for LOCK_MAX = 15 cycles with req[1] pending -> lock_timeout pulses once, then ack[1].
REQ-026 Range: write to addr 0x07FF -> ack and err, mem_wr_en stays 0; byte 0x7FF is unchanged.
REQ-027 Reset mid-ACCESS: assert reset in the ACCESS cycle of a write of 0xABCD to 0x0008 -> no ack, memory unchanged, state IDLE.
